// File: rtl/gates_tt_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gates_tt_seq_pkg                                                         |
// | Shared FSM encoding and golden truth table for the gate-bank sweeper.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package gates_tt_seq_pkg;

    localparam int c_state_w = 2;

    localparam logic [c_state_w-1:0] c_st_idle   = 2'd0;
    localparam logic [c_state_w-1:0] c_st_drive  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_sample = 2'd2;
    localparam logic [c_state_w-1:0] c_st_done   = 2'd3;

    // Slot i = {and,nand,or,nor,xor,xnor} for a=i[1], b=i[0].
    localparam logic [23:0] TT_GOLD = 24'hA5A695;

    localparam logic [3:0][5:0] EXP = TT_GOLD;

endpackage
`default_nettype wire

// File: rtl/gates2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gates2                                                                   |
// | Six-function 2-input gate bank: {and,nand,or,nor,xor,xnor}, MSB first.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gates2 (
    input  logic       i_a,
    input  logic       i_b,
    output logic [5:0] o_z
);

    assign o_z = {i_a & i_b, ~(i_a & i_b), i_a | i_b, ~(i_a | i_b), i_a ^ i_b, ~(i_a ^ i_b)};

endmodule
`default_nettype wire

// File: rtl/gates_tt_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gates_tt_seq                                                             |
// | Sweeps the gates2 bank over all four input vectors and checks results.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gates_tt_seq
    import gates_tt_seq_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  inv_mask,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  err_vec,
    output logic [23:0] tt
);

    localparam int              c_cw       = $clog2(DWELL + 1);
    localparam logic [c_cw-1:0] c_cnt_load = c_cw'(DWELL - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_next;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_inc;
    logic [c_cw-1:0]      r_cnt;
    logic                 r_a;
    logic                 r_b;
    logic                 r_pass;
    logic [3:0]           r_err;
    logic [23:0]          r_tt;
    logic [5:0]           w_z;
    logic [5:0]           w_cap;
    logic                 w_mis;
    logic                 w_accept;
    logic                 w_last;
    logic [3:0]           w_err_next;
    logic [23:0]          w_tt_next;

    gates2 u_gates2 (
        .i_a (r_a),
        .i_b (r_b),
        .o_z (w_z)
    );

    assign w_cap     = w_z ^ inv_mask;
    assign w_mis     = (w_cap != EXP[r_idx]);
    assign w_accept  = start && !abort;
    assign w_last    = (r_idx == 2'd3);
    assign w_idx_inc = r_idx + 2'd1;

    always_comb begin
        w_err_next        = r_err;
        w_err_next[r_idx] = w_mis;
        w_tt_next         = r_tt;
        for (int i = 0; i < 4; i++) begin
            if (r_idx == 2'(i)) begin
                w_tt_next[6*i +: 6] = w_cap;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (w_accept) w_state_next = c_st_drive;
            c_st_drive: begin
                if (abort)              w_state_next = c_st_idle;
                else if (r_cnt == '0)   w_state_next = c_st_sample;
            end
            c_st_sample: begin
                if (abort)              w_state_next = c_st_idle;
                else if (w_last)        w_state_next = c_st_done;
                else                    w_state_next = c_st_drive;
            end
            default:                    w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_st_drive, c_st_sample: busy = 1'b1;
            c_st_done:               done = 1'b1;
            default: ;
        endcase
    end

    // pass is resolved on entry to DONE so it is valid alongside the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= 2'd0;
            r_cnt  <= '0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= 4'd0;
            r_tt   <= 24'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_idx <= 2'd0;
                        r_cnt <= c_cnt_load;
                        r_a   <= 1'b0;
                        r_b   <= 1'b0;
                        r_err <= 4'd0;
                        r_tt  <= 24'd0;
                    end
                end
                c_st_drive: begin
                    if (!abort && r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cw'(1);
                    end
                end
                c_st_sample: begin
                    if (!abort) begin
                        r_err <= w_err_next;
                        r_tt  <= w_tt_next;
                        if (w_last) begin
                            r_pass <= (w_err_next == 4'd0);
                        end else begin
                            r_idx <= w_idx_inc;
                            r_cnt <= c_cnt_load;
                            r_a   <= w_idx_inc[1];
                            r_b   <= w_idx_inc[0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass    = r_pass;
    assign err_vec = r_err;
    assign tt      = r_tt;

endmodule
`default_nettype wire
